// File: rtl/qdr_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// qdr_sram_responder_pkg
// Shared widths and state encodings for the QDR SRAM responder.
//   QDR_BEAT_W   : width of one data beat on the user port
//   QDR_BURST_W  : width of one stored burst (two beats)
//   cal_state_t  : calibration emulation states
//   wr_state_t   : write burst assembly states
// -----------------------------------------------------------------------------
package qdr_sram_responder_pkg;

    localparam int QDR_BEAT_W  = 72;
    localparam int QDR_BURST_W = 2 * QDR_BEAT_W;

    typedef enum logic [1:0] {
        CAL_WAIT = 2'd0,
        CAL_DONE = 2'd1,
        CAL_FAIL = 2'd2
    } cal_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_BEAT1 = 1'b1
    } wr_state_t;

endpackage

// File: rtl/qdr_resp_rd_pipe.sv
// -----------------------------------------------------------------------------
// qdr_resp_rd_pipe
// Fixed-latency valid/address delay line for accepted read requests.
// A request entering on in_vld appears on out_vld exactly DEPTH cycles later.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (empties the pipe)
//   in_vld    in   accepted read request this cycle
//   in_addr   in   burst index of the request
//   out_vld   out  request leaving the pipe this cycle
//   out_addr  out  burst index of the leaving request
// -----------------------------------------------------------------------------
module qdr_resp_rd_pipe #(
    parameter int DEPTH = 10,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    addr_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts from the pre-edge value of its neighbour, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[DEPTH-2:0], in_vld};
            addr_q[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/qdr_sram_responder.sv
// -----------------------------------------------------------------------------
// qdr_sram_responder
// Behavioural stand-in for a QDR controller user port. Emulates calibration,
// assembles 2-beat write bursts into an internal RAM and answers 2-beat read
// bursts after a fixed latency.
// Ports:
//   qdr_clk      in   sole clock
//   qdr_rst_n    in   asynchronous active-low reset
//   phy_rdy      out  calibration passed; commands accepted only while high
//   cal_fail     out  calibration failed (FORCE_CAL_FAIL=1)
//   qdr_addr     in   burst address; only the low ADDR_WIDTH bits are used
//   qdr_wr_en    in   write burst start pulse (beat0 on qdr_wr_data)
//   qdr_wr_data  in   beat0 in the wr_en cycle, beat1 in the following cycle
//   qdr_rd_en    in   read burst request pulse
//   qdr_rd_data  out  read beat0 (upper half) then beat1 (lower half); 0 when idle
//   qdr_rd_dvld  out  high for two consecutive cycles per accepted read
//   proto_err    out  sticky flag: some command was dropped since reset
// -----------------------------------------------------------------------------
module qdr_sram_responder
    import qdr_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int RD_LATENCY     = 10,
    parameter int CAL_DELAY      = 64,
    parameter bit FORCE_CAL_FAIL = 1'b0
) (
    input  logic                  qdr_clk,
    input  logic                  qdr_rst_n,
    output logic                  phy_rdy,
    output logic                  cal_fail,
    input  logic [31:0]           qdr_addr,
    input  logic                  qdr_wr_en,
    input  logic [QDR_BEAT_W-1:0] qdr_wr_data,
    input  logic                  qdr_rd_en,
    output logic [QDR_BEAT_W-1:0] qdr_rd_data,
    output logic                  qdr_rd_dvld,
    output logic                  proto_err
);

    localparam int CAL_W = (CAL_DELAY > 1) ? $clog2(CAL_DELAY) : 1;

    // Upper address bits alias onto the RAM and are deliberately unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^qdr_addr[31:ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] cmd_addr;
    assign cmd_addr = qdr_addr[ADDR_WIDTH-1:0];

    // ---------------------------------------------------------------- calibration
    cal_state_t       cal_state, cal_next;
    logic [CAL_W-1:0] cal_cnt;
    logic             cal_cnt_done;

    assign cal_cnt_done = (cal_cnt == CAL_W'(CAL_DELAY - 1));

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            cal_state <= CAL_WAIT;
            cal_cnt   <= '0;
        end else begin
            cal_state <= cal_next;
            if (cal_state == CAL_WAIT && !cal_cnt_done) begin
                cal_cnt <= cal_cnt + 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cal_next = cal_state;
        case (cal_state)
            CAL_WAIT: if (cal_cnt_done) cal_next = FORCE_CAL_FAIL ? CAL_FAIL : CAL_DONE;
            CAL_DONE: cal_next = CAL_DONE;
            CAL_FAIL: cal_next = CAL_FAIL;
            default:  cal_next = CAL_WAIT;
        endcase
    end

    assign phy_rdy  = (cal_state == CAL_DONE);
    assign cal_fail = (cal_state == CAL_FAIL);

    // ---------------------------------------------------------------- write path
    wr_state_t             wr_state, wr_next;
    logic                  wr_accept, wr_commit, wr_drop;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [QDR_BEAT_W-1:0] wr_beat0;

    always_comb begin
        wr_next   = wr_state;
        wr_accept = 1'b0;
        wr_commit = 1'b0;
        wr_drop   = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (qdr_wr_en) begin
                    if (phy_rdy) begin
                        wr_accept = 1'b1;
                        wr_next   = WR_BEAT1;
                    end else begin
                        wr_drop = 1'b1;
                    end
                end
            end
            WR_BEAT1: begin
                // The burst always completes; a new wr_en here has no slot.
                wr_commit = 1'b1;
                wr_drop   = qdr_wr_en;
                wr_next   = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wr_beat0 <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_accept) begin
                wr_addr  <= cmd_addr;
                wr_beat0 <= qdr_wr_data;
            end
        end
    end

    // ---------------------------------------------------------------- storage
    logic [QDR_BURST_W-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the RAM array has no reset so it maps onto plain RAM/LUT storage;
    // its contents are undefined until written.
    always_ff @(posedge qdr_clk) begin
        if (wr_commit) begin
            mem[wr_addr] <= {wr_beat0, qdr_wr_data};
        end
    end

    // ---------------------------------------------------------------- read path
    logic                   rd_accept, rd_drop, rd_acc_q;
    logic                   pipe_vld;
    logic [ADDR_WIDTH-1:0]  pipe_addr;
    logic [QDR_BURST_W-1:0] exit_word;
    logic                   beat1_vld;
    logic [QDR_BEAT_W-1:0]  beat1_data;

    // A read right behind an accepted read would overlap its second beat.
    assign rd_accept = qdr_rd_en && phy_rdy && !rd_acc_q;
    assign rd_drop   = qdr_rd_en && !rd_accept;

    qdr_resp_rd_pipe #(
        .DEPTH (RD_LATENCY),
        .AW    (ADDR_WIDTH)
    ) u_rd_pipe (
        .clk      (qdr_clk),
        .rst_n    (qdr_rst_n),
        .in_vld   (rd_accept),
        .in_addr  (cmd_addr),
        .out_vld  (pipe_vld),
        .out_addr (pipe_addr)
    );

    // The whole burst is read at pipe exit; beat1 is held for one cycle.
    assign exit_word = mem[pipe_addr];

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            rd_acc_q   <= 1'b0;
            beat1_vld  <= 1'b0;
            beat1_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            rd_acc_q   <= rd_accept;
            beat1_vld  <= pipe_vld;
            beat1_data <= pipe_vld ? exit_word[QDR_BEAT_W-1:0] : '0;
            proto_err  <= proto_err | wr_drop | rd_drop;
        end
    end

    assign qdr_rd_dvld = pipe_vld | beat1_vld;
    assign qdr_rd_data = pipe_vld ? exit_word[QDR_BURST_W-1:QDR_BEAT_W] : beat1_data;

endmodule
